// File: rtl/mult_pkg.sv
// Shared types and default sizing for the multiplier-sharing arbiter slice.
package mult_pkg;

  localparam int DefaultWidth  = 4;
  localparam int DefaultNumReq = 4;

  typedef logic [DefaultWidth-1:0]   multiplicand_t;
  typedef logic [2*DefaultWidth-1:0] product_t;

  typedef struct packed {
    logic [$clog2(DefaultNumReq)-1:0] id;
    product_t                         product;
  } rsp_t;

endpackage

// File: rtl/multiplier.sv
// Purely combinational unsigned multiplier; the product is wide enough to never overflow.
module multiplier #(
  parameter int Width = 4
) (
  input  logic [Width-1:0]   a_i,
  input  logic [Width-1:0]   b_i,
  output logic [2*Width-1:0] p_o
);

  assign p_o = {{Width{1'b0}}, a_i} * {{Width{1'b0}}, b_i};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans from ptr with wrap, grants only when enabled, and
// moves ptr just past the winner on every grant.
module rr_arbiter #(
  parameter  int NumReq = 4,
  localparam int IdW    = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  input  logic              en_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdW-1:0]    gnt_idx_o
);

  logic [IdW-1:0] ptr_q;
  logic [IdW:0]   cand;
  logic           found;

  // One extra bit on the candidate index keeps the modulo wrap exact for any NumReq.
  always_comb begin
    found     = 1'b0;
    gnt_idx_o = '0;
    cand      = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = {1'b0, ptr_q} + (IdW+1)'(k);
      if (cand >= (IdW+1)'(NumReq)) cand = cand - (IdW+1)'(NumReq);
      if (!found && req_i[cand[IdW-1:0]]) begin
        found     = 1'b1;
        gnt_idx_o = cand[IdW-1:0];
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (en_i && found) gnt_o[gnt_idx_o] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (en_i && found) begin
      ptr_q <= (gnt_idx_o == IdW'(NumReq-1)) ? '0 : gnt_idx_o + IdW'(1);
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one multiplier among NumReq requesters; the winner's product and index
// are registered on a single valid/ready response port.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter  int Width  = DefaultWidth,
  parameter  int NumReq = DefaultNumReq,
  localparam int IdW    = $clog2(NumReq)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq-1:0][Width-1:0] req_a_i,
  input  logic [NumReq-1:0][Width-1:0] req_b_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [IdW-1:0]               rsp_id_o,
  output logic [2*Width-1:0]           rsp_product_o
);

  typedef struct packed {
    logic [IdW-1:0]     id;
    logic [2*Width-1:0] product;
  } rsp_reg_t;

  rsp_reg_t           rsp_q;
  logic               rsp_valid_q;
  logic               can_load;
  logic               accept;
  logic [NumReq-1:0]  gnt;
  logic [IdW-1:0]     gnt_idx;
  logic [Width-1:0]   mux_a;
  logic [Width-1:0]   mux_b;
  logic [2*Width-1:0] product;

  // Gating with rst_ni drops every ready the moment reset is asserted.
  assign can_load = rst_ni && (!rsp_valid_q || rsp_ready_i);
  assign accept   = |gnt;

  rr_arbiter #(.NumReq(NumReq)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_valid_i),
    .en_i      (can_load),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign mux_a = req_a_i[gnt_idx];
  assign mux_b = req_b_i[gnt_idx];

  multiplier #(.Width(Width)) u_mult (
    .a_i (mux_a),
    .b_i (mux_b),
    .p_o (product)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else if (accept) begin
      rsp_valid_q   <= 1'b1;
      rsp_q.id      <= gnt_idx;
      rsp_q.product <= product;
    end else if (rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign req_ready_o   = gnt;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_id_o      = rsp_q.id;
  assign rsp_product_o = rsp_q.product;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed and scoreboarded checks of the shared-multiplier round-robin arbiter.
module tb_mult_arbiter;

  localparam int Width  = 4;
  localparam int NumReq = 4;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [NumReq-1:0]            req_valid;
  logic [NumReq-1:0]            req_ready;
  logic [NumReq-1:0][Width-1:0] req_a;
  logic [NumReq-1:0][Width-1:0] req_b;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [1:0]                   rsp_id;
  logic [7:0]                   rsp_product;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.Width(Width), .NumReq(NumReq)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_a_i       (req_a),
    .req_b_i       (req_b),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_id_o      (rsp_id),
    .rsp_product_o (rsp_product)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    tests++;
    if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", rsp_valid); end
    tests++;
    if (rsp_id !== 2'd0) begin fails++; $display("[TB] FAIL reset_id: got %0d expected 0", rsp_id); end
    tests++;
    if (rsp_product !== 8'd0) begin fails++; $display("[TB] FAIL reset_product: got %0d expected 0", rsp_product); end
    req_valid = 4'b1111;
    #1;
    tests++;
    if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single();
    req_valid = 4'b0100; req_a[2] = 4'd2; req_b[2] = 4'd7; rsp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin fails++; $display("[TB] FAIL single_ready: got %b expected 0100", req_ready); end
    tick();
    req_valid = '0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_product !== 8'd14) begin
      fails++; $display("[TB] FAIL single_rsp: got v=%b id=%0d p=%0d expected v=1 id=2 p=14", rsp_valid, rsp_id, rsp_product);
    end
    tick();
    tests++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd2 || rsp_product !== 8'd14) begin
      fails++; $display("[TB] FAIL drain_hold: got v=%b id=%0d p=%0d expected v=0 id=2 p=14", rsp_valid, rsp_id, rsp_product);
    end
  endtask

  task automatic test_round_robin();
    int prod_tab[4] = '{78, 70, 11, 225};
    do_reset();
    req_a[0] = 4'd13; req_b[0] = 4'd6;
    req_a[1] = 4'd5;  req_b[1] = 4'd14;
    req_a[2] = 4'd11; req_b[2] = 4'd1;
    req_a[3] = 4'd15; req_b[3] = 4'd15;
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      tests++;
      if (req_ready !== (4'b0001 << (k % 4))) begin
        fails++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, 4'b0001 << (k % 4));
      end
      tick();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_product !== 8'(prod_tab[k % 4])) begin
        fails++; $display("[TB] FAIL rr_rsp[%0d]: got v=%b id=%0d p=%0d expected v=1 id=%0d p=%0d",
                          k, rsp_valid, rsp_id, rsp_product, k % 4, prod_tab[k % 4]);
      end
    end
  endtask

  task automatic test_backpressure();
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin fails++; $display("[TB] FAIL bp_pre_ready: got %b expected 0001", req_ready); end
    tick();
    rsp_ready = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_product !== 8'd78 || req_ready !== 4'b0000) begin
      fails++; $display("[TB] FAIL bp_hold_start: got v=%b id=%0d p=%0d rdy=%b expected v=1 id=0 p=78 rdy=0000",
                        rsp_valid, rsp_id, rsp_product, req_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_product !== 8'd78 || req_ready !== 4'b0000) begin
        fails++; $display("[TB] FAIL bp_hold[%0d]: got v=%b id=%0d p=%0d rdy=%b expected v=1 id=0 p=78 rdy=0000",
                          k, rsp_valid, rsp_id, rsp_product, req_ready);
      end
    end
    rsp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0010) begin fails++; $display("[TB] FAIL bp_release_ready: got %b expected 0010", req_ready); end
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_product !== 8'd70) begin
      fails++; $display("[TB] FAIL bp_release_rsp: got v=%b id=%0d p=%0d expected v=1 id=1 p=70", rsp_valid, rsp_id, rsp_product);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_pointer_skip();
    do_reset();
    req_a[1] = 4'd0; req_b[1] = 4'd5;
    req_a[3] = 4'd9; req_b[3] = 4'd3;
    req_valid = 4'b1010; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++;
      if (req_ready !== ((k % 2 == 0) ? 4'b0010 : 4'b1000)) begin
        fails++; $display("[TB] FAIL skip_ready[%0d]: got %b expected %b", k, req_ready, (k % 2 == 0) ? 4'b0010 : 4'b1000);
      end
      tick();
      tests++;
      if (rsp_id !== ((k % 2 == 0) ? 2'd1 : 2'd3) || rsp_product !== ((k % 2 == 0) ? 8'd0 : 8'd27)) begin
        fails++; $display("[TB] FAIL skip_rsp[%0d]: got id=%0d p=%0d expected id=%0d p=%0d", k, rsp_id, rsp_product,
                          (k % 2 == 0) ? 1 : 3, (k % 2 == 0) ? 0 : 27);
      end
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    req_a[0] = 4'd13; req_b[0] = 4'd6;
    req_valid = 4'b1111;
    #2;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_product !== 8'd27) begin
      fails++; $display("[TB] FAIL mid_pre: got v=%b id=%0d p=%0d expected v=1 id=3 p=27", rsp_valid, rsp_id, rsp_product);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_product !== 8'd0 || req_ready !== 4'b0000) begin
      fails++; $display("[TB] FAIL mid_reset: got v=%b id=%0d p=%0d rdy=%b expected all zero",
                        rsp_valid, rsp_id, rsp_product, req_ready);
    end
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin fails++; $display("[TB] FAIL mid_tie_ready: got %b expected 0001", req_ready); end
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_product !== 8'd78) begin
      fails++; $display("[TB] FAIL mid_tie_rsp: got v=%b id=%0d p=%0d expected v=1 id=0 p=78", rsp_valid, rsp_id, rsp_product);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_exhaustive();
    logic [7:0] pair;
    logic [1:0] idx;
    logic [1:0] gi;
    logic [3:0] exp_gnt;
    logic [1:0] qid[$];
    logic [7:0] qprod[$];
    bit         has[NumReq];
    bit         mvalid;
    bit         can;
    bit         got;
    int         next;
    int         responses;
    int         cycles;
    logic [1:0] mptr;
    logic [1:0] eid;
    logic [7:0] eprod;

    for (int i = 0; i < NumReq; i++) has[i] = 1'b0;
    next = 0; responses = 0; cycles = 0; mvalid = 1'b0; mptr = 2'd0;
    req_valid = '0;
    do_reset();
    while (responses < 256 && cycles < 6000) begin
      for (int i = 0; i < NumReq; i++) begin
        if (!has[i] && next < 256) begin
          pair = next[7:0];
          req_a[i] = pair[7:4];
          req_b[i] = pair[3:0];
          has[i] = 1'b1;
          next++;
        end
        req_valid[i] = has[i] && ($urandom_range(3) != 0);
      end
      rsp_ready = ($urandom_range(3) != 0);
      #1;
      can = !mvalid || rsp_ready;
      exp_gnt = '0; got = 1'b0; gi = '0;
      if (can) begin
        for (int k = 0; k < NumReq; k++) begin
          idx = mptr + 2'(k);
          if (!got && req_valid[idx]) begin got = 1'b1; gi = idx; end
        end
      end
      if (got) exp_gnt[gi] = 1'b1;
      tests++;
      if (req_ready !== exp_gnt) begin
        fails++; $display("[TB] FAIL exh_ready[cyc %0d]: got %b expected %b", cycles, req_ready, exp_gnt);
      end
      tests++;
      if (rsp_valid !== mvalid) begin
        fails++; $display("[TB] FAIL exh_valid[cyc %0d]: got %b expected %b", cycles, rsp_valid, mvalid);
      end
      if (mvalid && rsp_ready) begin
        tests++;
        if (qid.size() == 0) begin
          fails++; $display("[TB] FAIL exh_order: response with empty scoreboard at cycle %0d", cycles);
        end else begin
          eid = qid.pop_front();
          eprod = qprod.pop_front();
          if (rsp_id !== eid || rsp_product !== eprod) begin
            fails++; $display("[TB] FAIL exh_rsp[%0d]: got id=%0d p=%0d expected id=%0d p=%0d",
                              responses, rsp_id, rsp_product, eid, eprod);
          end
        end
        responses++;
        mvalid = 1'b0;
      end
      if (got) begin
        qid.push_back(gi);
        qprod.push_back(8'(int'(req_a[gi]) * int'(req_b[gi])));
        has[gi] = 1'b0;
        mptr = gi + 2'd1;
        mvalid = 1'b1;
      end
      tick();
      cycles++;
    end
    tests++;
    if (responses != 256 || qid.size() != 0) begin
      fails++; $display("[TB] FAIL exh_count: got %0d responses (%0d pending) expected 256 (0 pending)", responses, qid.size());
    end
    req_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    #2;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_single();
    test_round_robin();
    test_backpressure();
    test_pointer_skip();
    test_reset_mid();
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Shares one combinational `multiplier` instance between `NumReq` independent requesters. Each requester presents an operand pair under a valid/ready handshake. A round-robin arbiter picks one requester per cycle and feeds its operands to the multiplier. The product is registered together with the winning requester's index and returned on a single valid/ready response port.

## Interface
- `Width`, 4, operand width in bits; product is `2*Width` bits.
- `NumReq`, 4, number of requesters; must be ≥ 2.
- `IdW`, `$clog2(NumReq)` (localparam), width of requester index.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous assert, active-low.
- `req_valid_i`  in  `[NumReq]`  requester i has an operand pair.
- `req_ready_o`  out  `[NumReq]`  requester i's pair is accepted this cycle.
- `req_a_i`  in  `[NumReq][Width]`  multiplicand per requester.
- `req_b_i`  in  `[NumReq][Width]`  multiplier per requester.
- `rsp_valid_o`  out  1  response register holds a result.
- `rsp_ready_i`  in  1  consumer takes the result.
- `rsp_id_o`  out  `IdW`  index of the requester that owns the result.
- `rsp_product_o`  out  `2*Width`  unsigned product `a*b`.

## Operation
- **Response register.** Holds `{valid, id, product}`. The register may load when `!rsp_valid_o || rsp_ready_i`; call this condition `can_load`.
- **Arbitration.** When `can_load` is true, the arbiter grants the first `req_valid_i[i]` found scanning from `ptr`, `ptr+1`, … with wrap modulo `NumReq`.
  - `req_ready_o` is one-hot (the grant) or all zero.
  - `req_ready_o` may depend combinationally on `req_valid_i` and `rsp_ready_i`.
  - `req_ready_o` is all zero when `can_load` is false.
- **Pointer.** On an accepted transfer from requester g, `ptr <= (g+1) mod NumReq`. Otherwise `ptr` holds.
- **Datapath.** The granted operands are muxed into `multiplier`. On acceptance:
  - `rsp_product_o <= a*b`, `rsp_id_o <= g`, `rsp_valid_o <= 1`.
- **Drain.** If `rsp_ready_i && rsp_valid_o` and there is no new acceptance, `rsp_valid_o <= 0`. `rsp_id_o` and `rsp_product_o` hold their last values.
- **Requester rules.** Requesters hold valid and operands stable until ready. Dropping valid before ready is legal; that request is simply not granted.
- **Arithmetic.** Unsigned throughout, no overflow: the `2*Width` product width covers the full range.
- **Simultaneous drain and accept.** Back-to-back transfer: the new result overwrites the old one in the same edge, and `rsp_valid_o` stays 1.

## Timing
- **Reset values.** `rsp_valid_o=0`, `rsp_id_o=0`, `rsp_product_o=0`, `ptr=0` (requester 0 has highest priority first).
- **Reset mid-operation.** The held response is discarded immediately and `req_ready_o` goes to 0 asynchronously. No pending request is remembered.
- **Latency.** A request accepted at edge N is visible on `rsp_*` after edge N, i.e. in cycle N+1.
- **Throughput.** One result per cycle while `rsp_ready_i=1`.
- **Backpressure.** With `rsp_valid_o=1` and `rsp_ready_i=0`:
  - outputs are stable;
  - all `req_ready_o` are 0;
  - `ptr` is frozen.
- **Fairness.** With all requesters continuously valid and no backpressure, grants cycle 0,1,…,NumReq-1,0,…. Any requester waits at most `NumReq-1` accepted transfers.

## Structure
- **Shared package `mult_pkg`:**
  - `multiplicand_t` (`logic [Width-1:0]`);
  - `product_t` (`logic [2*Width-1:0]`);
  - a response struct `{id, product}`;
  - default `Width`.
- **Sub-module `rr_arbiter`:**
  - parameter `NumReq`;
  - inputs `clk_i`, `rst_ni`, `req_i`, `en_i`;
  - outputs one-hot `gnt_o` and `gnt_idx_o`;
  - owns `ptr` and advances it only when `en_i && |req_i`.
- **`mult_arbiter` top.** Instantiates `rr_arbiter`, the operand mux, `multiplier #(.Width(Width))` and the response register.

## Test plan
- **Single request.** Only requester 2 valid with a=2, b=7, `rsp_ready_i=1` → `req_ready_o=4'b0100` in that cycle; next cycle `rsp_valid_o=1`, `rsp_id_o=2`, `rsp_product_o=14`.
- **Round-robin order.** All four valid continuously, operands (13,6),(5,14),(11,1),(15,15) on requesters 0..3, `rsp_ready_i=1` → ids 0,1,2,3,0… on consecutive cycles with products 78,70,11,225.
- **Backpressure.** Response of 78 held with `rsp_ready_i=0` for 3 cycles → outputs unchanged, `req_ready_o=0`. On release: back-to-back accept, next id follows the last granted.
- **Pointer skip.** Only requesters 1 and 3 valid, starting `ptr=0` → grants 1,3,1,3. Operands (0,5) give product 0.
- **Reset mid-operation.** Assert `rst_ni=0` while `rsp_valid_o=1` → `rsp_valid_o`, `rsp_id_o` and `rsp_product_o` all 0 immediately. After release, requester 0 wins a 4-way tie.
- **Exhaustive operands.** Random valid/ready pattern over all 256 (a,b) pairs → every accepted request yields exactly one response with the matching id and `a*b`, in acceptance order.
